fpsqrt_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined `FpSqrt` unit between `N_REQ` requesters. It accepts single-precision operands over a valid/ready handshake and drives the unit's `iA` input. It tags each issued operation in a shadow pipeline matching the unit's latency, then returns either `Sqrt` or `oInvSqrt` to the issuing requester with its ID. Special operands (zero, negative, NaN) bypass the unit's arithmetic and get IEEE-754 results.

---
 rtl/fpsqrt_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpsqrt_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpsqrt_arbiter.sv
// fpsqrt_arbiter: round-robin front end sharing one pipelined FpSqrt unit.
// A shadow tag pipeline carries requester, mode and operand class to the output.
module fpsqrt_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int SQRT_LAT = 4,
    parameter  int IDW      = $clog2(N_REQ),
    localparam int CW       = $clog2(SQRT_LAT + 1) + 1
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iFlush,
    input  logic [N_REQ-1:0]    iReq_valid,
    input  logic [32*N_REQ-1:0] iReq_a,
    input  logic [N_REQ-1:0]    iReq_inv,
    output logic [N_REQ-1:0]    oReq_ready,
    output logic [31:0]         oSqrt_a,
    input  logic [31:0]         iSqrt_res,
    input  logic [31:0]         iInvSqrt_res,
    output logic                oRes_valid,
    output logic [IDW-1:0]      oRes_id,
    output logic                oRes_inv,
    output logic [31:0]         oRes_data,
    output logic [CW-1:0]       oInflight,
    output logic                oBusy
);

    typedef enum logic [2:0] {
        CL_NORM, CL_PZERO, CL_NZERO, CL_NAN, CL_PINF
    } cls_e;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           inv;
        cls_e           cls;
    } tag_t;

    logic [IDW-1:0] r_rr;
    logic [31:0]    r_sqrt_a;
    tag_t           r_tag [SQRT_LAT];
    logic           r_res_valid;
    logic [IDW-1:0] r_res_id;
    logic           r_res_inv;
    logic [31:0]    r_res_data;
    logic [CW-1:0]  r_cnt;

    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_gid;
    logic [31:0]      w_a;
    logic             w_inv;
    logic             w_acc;
    tag_t             w_last;
    logic [31:0]      w_res_data;
    logic [IDW-1:0]   w_rr_next;

    // Denormals fold into the signed-zero classes.
    function automatic cls_e classify(input logic [31:0] a);
        cls_e c;
        if (a[30:23] == 8'h00)
            c = a[31] ? CL_NZERO : CL_PZERO;
        else if (a[31] || (a[30:23] == 8'hFF && a[22:0] != 23'd0))
            c = CL_NAN;
        else if (a[30:23] == 8'hFF)
            c = CL_PINF;
        else
            c = CL_NORM;
        return c;
    endfunction

    // Descending scans: last write wins, so indices >= rr take priority.
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_a     = '0;
        w_inv   = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (iReq_valid[j] && IDW'(j) < r_rr) begin
                w_grant    = '0;
                w_grant[j] = 1'b1;
                w_gid      = IDW'(j);
                w_a        = iReq_a[32*j +: 32];
                w_inv      = iReq_inv[j];
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (iReq_valid[j] && IDW'(j) >= r_rr) begin
                w_grant    = '0;
                w_grant[j] = 1'b1;
                w_gid      = IDW'(j);
                w_a        = iReq_a[32*j +: 32];
                w_inv      = iReq_inv[j];
            end
        end
    end

    assign oReq_ready = iFlush ? '0 : w_grant;
    assign w_acc      = |oReq_ready;
    assign w_rr_next  = (w_gid == IDW'(N_REQ - 1)) ? '0 : w_gid + IDW'(1);
    assign w_last     = r_tag[SQRT_LAT-1];

    always_comb begin
        w_res_data = 32'h7FC0_0000;
        unique case (w_last.cls)
            CL_NORM:  w_res_data = w_last.inv ? iInvSqrt_res : iSqrt_res;
            CL_PZERO: w_res_data = w_last.inv ? 32'h7F80_0000 : 32'h0000_0000;
            CL_NZERO: w_res_data = w_last.inv ? 32'hFF80_0000 : 32'h8000_0000;
            CL_PINF:  w_res_data = w_last.inv ? 32'h0000_0000 : 32'h7F80_0000;
            default:  w_res_data = 32'h7FC0_0000;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rr        <= '0;
            r_sqrt_a    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_inv   <= 1'b0;
            r_res_data  <= '0;
            r_cnt       <= '0;
            for (int i = 0; i < SQRT_LAT; i++)
                r_tag[i] <= '0;
        end else begin
            if (w_acc) begin
                r_sqrt_a <= w_a;
                r_rr     <= w_rr_next;
            end
            r_tag[0] <= iFlush ? '0 : '{vld: w_acc, id: w_gid,
                                        inv: w_inv, cls: classify(w_a)};
            for (int i = 1; i < SQRT_LAT; i++)
                r_tag[i] <= iFlush ? '0 : r_tag[i-1];
            r_res_valid <= iFlush ? 1'b0 : w_last.vld;
            if (!iFlush && w_last.vld) begin
                r_res_id   <= w_last.id;
                r_res_inv  <= w_last.inv;
                r_res_data <= w_res_data;
            end
            // An operation stays counted through its output-register cycle.
            if (iFlush)
                r_cnt <= '0;
            else if (w_acc && !r_res_valid)
                r_cnt <= r_cnt + CW'(1);
            else if (!w_acc && r_res_valid)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    assign oSqrt_a    = r_sqrt_a;
    assign oRes_valid = r_res_valid;
    assign oRes_id    = r_res_id;
    assign oRes_inv   = r_res_inv;
    assign oRes_data  = r_res_data;
    assign oInflight  = r_cnt;
    assign oBusy      = (r_cnt != '0);

endmodule

// File: tb/tb_fpsqrt_arbiter.sv
// tb_fpsqrt_arbiter: directed steps with a result scoreboard.
// A behavioural FpSqrt stand-in drives iSqrt_res/iInvSqrt_res.
module tb_fpsqrt_arbiter;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int CW = $clog2(L + 1) + 1;

    typedef struct packed {
        logic [1:0]  id;
        logic        inv;
        logic [31:0] data;
    } exp_t;

    logic            iCLK = 1'b0;
    logic            iRST_n;
    logic            iFlush;
    logic [N-1:0]    iReq_valid;
    logic [32*N-1:0] iReq_a;
    logic [N-1:0]    iReq_inv;
    logic [N-1:0]    oReq_ready;
    logic [31:0]     oSqrt_a;
    logic [31:0]     iSqrt_res;
    logic [31:0]     iInvSqrt_res;
    logic            oRes_valid;
    logic [1:0]      oRes_id;
    logic            oRes_inv;
    logic [31:0]     oRes_data;
    logic [CW-1:0]   oInflight;
    logic            oBusy;

    int          n_vec;
    int          n_err;
    int          maxv;
    exp_t        sb [$];
    logic [1:0]  m_rr;
    logic [31:0] pipe [L-1];
    logic [31:0] sp [6];

    fpsqrt_arbiter #(.N_REQ(N), .SQRT_LAT(L)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iFlush(iFlush),
        .iReq_valid(iReq_valid), .iReq_a(iReq_a), .iReq_inv(iReq_inv),
        .oReq_ready(oReq_ready), .oSqrt_a(oSqrt_a),
        .iSqrt_res(iSqrt_res), .iInvSqrt_res(iInvSqrt_res),
        .oRes_valid(oRes_valid), .oRes_id(oRes_id), .oRes_inv(oRes_inv),
        .oRes_data(oRes_data), .oInflight(oInflight), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] f_sqrt(input logic [31:0] a);
        return (a == 32'h4080_0000) ? 32'h4000_0000 : (a ^ 32'h0F0F_1234);
    endfunction

    function automatic logic [31:0] f_inv(input logic [31:0] a);
        return (a == 32'h4080_0000) ? 32'h3F00_0000 : (a ^ 32'h7700_00FF);
    endfunction

    // The unit samples iA one edge after oSqrt_a loads, result L edges on.
    always @(posedge iCLK) begin
        pipe[0] <= oSqrt_a;
        for (int i = 1; i < L - 1; i++)
            pipe[i] <= pipe[i-1];
    end
    assign iSqrt_res    = f_sqrt(pipe[L-2]);
    assign iInvSqrt_res = f_inv(pipe[L-2]);

    function automatic logic [31:0] exp_res(input logic [31:0] a, input logic inv);
        if (a[30:23] == 8'h00)
            return a[31] ? (inv ? 32'hFF80_0000 : 32'h8000_0000)
                         : (inv ? 32'h7F80_0000 : 32'h0000_0000);
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return 32'h7FC0_0000;
        if (a[31]) return 32'h7FC0_0000;
        if (a[30:23] == 8'hFF) return inv ? 32'h0000_0000 : 32'h7F80_0000;
        return inv ? f_inv(a) : f_sqrt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   k;
        int   kk;
        if (oRes_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("stray_valid", {31'b0, oRes_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_id", {30'b0, oRes_id}, {30'b0, e.id});
                chk("res_inv", {31'b0, oRes_inv}, {31'b0, e.inv});
                chk("res_data", oRes_data, e.data);
            end
        end
        if (iFlush) sb.delete();
        kk = -1;
        if (!iFlush) begin
            for (int i = 0; i < N; i++) begin
                k = (int'(m_rr) + i) % N;
                if (kk < 0 && iReq_valid[k]) kk = k;
            end
        end
        chk("grant", {28'b0, oReq_ready}, (kk >= 0) ? (32'd1 << kk) : 32'd0);
        if (kk >= 0) begin
            sb.push_back('{id: 2'(kk), inv: iReq_inv[kk],
                           data: exp_res(iReq_a[32*kk +: 32], iReq_inv[kk])});
            m_rr = 2'((kk + 1) % N);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        monitor();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drain();
        repeat (L + 3) tick();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic inv);
        iReq_a[32*k +: 32] = a;
        iReq_inv[k]        = inv;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sqrt_a"}, oSqrt_a, 32'd0);
        chk({tag, "_valid"}, {31'b0, oRes_valid}, 32'd0);
        chk({tag, "_id"}, {30'b0, oRes_id}, 32'd0);
        chk({tag, "_inv"}, {31'b0, oRes_inv}, 32'd0);
        chk({tag, "_data"}, oRes_data, 32'd0);
        chk({tag, "_inflight"}, {28'b0, oInflight}, 32'd0);
        chk({tag, "_busy"}, {31'b0, oBusy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; m_rr = '0;
        iRST_n = 1'b0; iFlush = 1'b0;
        iReq_valid = '0; iReq_a = '0; iReq_inv = '0;
        sp[0] = 32'h0000_0000; sp[1] = 32'h8000_0000; sp[2] = 32'hBF80_0000;
        sp[3] = 32'h7F80_0000; sp[4] = 32'h7FC0_0001; sp[5] = 32'h0000_0001;
        repeat (2) @(posedge iCLK);
        #1;
        chk_reset("por");
        #3 iRST_n = 1'b1;
        tick();

        // Single requester, sqrt then 1/sqrt of 4.0
        set_req(0, 32'h4080_0000, 1'b0);
        iReq_valid = 4'b0001;
        #1 chk("ready_same_cycle", {28'b0, oReq_ready}, 32'h1);
        tick();
        iReq_valid = '0;
        chk("sqrt_a", oSqrt_a, 32'h4080_0000);
        chk("inflight_one", {28'b0, oInflight}, 32'd1);
        repeat (L) tick();
        chk("lat_valid", {31'b0, oRes_valid}, 32'd1);
        set_req(0, 32'h4080_0000, 1'b1);
        iReq_valid = 4'b0001;
        tick();
        iReq_valid = '0;
        repeat (L) tick();
        chk("lat_valid_inv", {31'b0, oRes_valid}, 32'd1);
        drain();

        // All four requesters contend continuously
        set_req(3, 32'h3F80_0000, 1'b0);
        iReq_valid = 4'b1000;
        tick();
        set_req(0, 32'h4210_0000, 1'b0);
        set_req(1, 32'h41CF_3333, 1'b1);
        set_req(2, 32'h40D6_6666, 1'b0);
        set_req(3, 32'h42FE_CCCD, 1'b1);
        iReq_valid = 4'b1111;
        maxv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (int'(oInflight) > maxv) maxv = int'(oInflight);
        end
        iReq_valid = '0;
        chk("inflight_max", maxv, L + 1);
        drain();

        // Special operands through requester 2, both modes
        iReq_valid = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            set_req(2, sp[i/2], (i % 2) == 1);
            tick();
        end
        iReq_valid = '0;
        drain();

        // Pointer at 2 with requesters 1 and 3 pending
        set_req(1, 32'h4040_0000, 1'b0);
        iReq_valid = 4'b0010;
        tick();
        set_req(3, 32'h4110_0000, 1'b0);
        iReq_valid = 4'b1010;
        #1 chk("rr2_first", {28'b0, oReq_ready}, 32'h8);
        tick();
        #1 chk("rr2_second", {28'b0, oReq_ready}, 32'h2);
        tick();
        iReq_valid = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            #1 chk("r3_every", {28'b0, oReq_ready}, 32'h8);
            tick();
        end
        iReq_valid = '0;
        drain();

        // Flush with three in flight and a request on the flush cycle
        iReq_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 32'h4000_0000 + 32'(i), 1'b0);
            tick();
        end
        set_req(0, 32'h4120_0000, 1'b0);
        iFlush = 1'b1;
        #1 chk("flush_ready", {28'b0, oReq_ready}, 32'd0);
        tick();
        iFlush = 1'b0;
        iReq_valid = '0;
        chk("flush_inflight", {28'b0, oInflight}, 32'd0);
        chk("flush_valid", {31'b0, oRes_valid}, 32'd0);
        chk("flush_busy", {31'b0, oBusy}, 32'd0);
        tick();
        iReq_valid = 4'b0001;
        tick();
        iReq_valid = '0;
        drain();

        // Asynchronous reset while busy
        set_req(0, 32'h4080_0000, 1'b1);
        iReq_valid = 4'b0001;
        tick();
        tick();
        iRST_n = 1'b0;
        iReq_valid = '0;
        sb.delete();
        m_rr = '0;
        #1 chk_reset("midrst");
        #2 iRST_n = 1'b1;
        repeat (L + 3) tick();
        iReq_valid = 4'b1111;
        #1 chk("post_rst_grant", {28'b0, oReq_ready}, 32'h1);
        tick();
        iReq_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
